dpram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the team's dual-port RAM between NUM_REQ requesters. Each requester presents a read or write request and holds it until granted. The arbiter issues the granted access to the RAM port through registered outputs and routes the read data back to the requester that issued it. One instance drives each RAM port: A and B are arbitrated independently.

---
 rtl/dpram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Round-robin arbiter sharing one dual-port RAM port between NUM_REQ
// requesters. The granted access is issued to the RAM through registered
// mem_* outputs; read data is routed back to the issuing requester two
// cycles after its grant. One instance per RAM port.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous, active-high reset
//   req        per-requester request valid, held until granted
//   req_we     per-requester direction (1 = write, 0 = read)
//   req_addr   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        one-hot grant, combinational, same cycle as acceptance
//   rsp_valid  one-hot read-response strobe, registered
//   rsp_data   read data, pass-through of mem_rdata
//   mem_addr   RAM port address (registered)
//   mem_wdata  RAM port write data (registered)
//   mem_we     RAM port write enable (registered)
//   mem_re     RAM port read enable (registered)
//   mem_rdata  RAM port read data, valid one cycle after mem_re
module dpram_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  output logic                             mem_re,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Requester index reached by stepping 'off' places up from 'base', modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [PTR_W-1:0]      win;
  logic [PTR_W-1:0]      cand;
  logic                  found;
  logic                  grant_any;
  logic                  win_we;

  // Read-response pipeline, stage 1 (cycle the RAM samples the read)
  logic                  rd_v1;
  logic [PTR_W-1:0]      rd_idx1;

  // Per-requester views of the packed address / write-data buses
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first requester at or above ptr (wrapping) wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = rr_index(ptr, k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // No grant is issued while reset is held.
  assign grant_any = found & ~rst;
  assign win_we    = req_we[win];
  assign ptr_nxt   = (win == LAST_IDX) ? '0 : win + 1'b1;

  always_comb begin
    gnt = '0;
    if (grant_any) gnt[win] = 1'b1;
  end

  // Issue stage, pointer update and response pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rd_v1     <= 1'b0;
      rd_idx1   <= '0;
      rsp_valid <= '0;
    end else begin
      mem_we  <= grant_any & win_we;
      mem_re  <= grant_any & ~win_we;
      rd_v1   <= grant_any & ~win_we;
      rd_idx1 <= win;
      if (grant_any) begin
        ptr       <= ptr_nxt;
        mem_addr  <= addr_arr[win];
        mem_wdata <= wdata_arr[win];
      end
      rsp_valid <= rd_v1 ? (NUM_REQ'(1) << rd_idx1) : '0;
    end
  end

  // RAM read data is already aligned with rsp_valid.
  assign rsp_data = mem_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 1-cycle RAM and
// a response scoreboard keyed on the expected arrival cycle.
module tb_dpram_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req;
  logic [NR-1:0]      req_we;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR-1:0]      gnt;
  logic [NR-1:0]      rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [DW-1:0]      mem_rdata;

  dpram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM port: registered read, 1-cycle latency.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  exp_t          mon_e;
  logic [DW-1:0] exp_mem [256];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = 1'b1;
    req_we[i]         = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Expect a read response two cycles after the grant seen in this cycle.
  task automatic push(input logic [NR-1:0] vld, input logic [DW-1:0] data);
    exp_t e;
    e.cyc  = cyc + 2;
    e.vld  = vld;
    e.data = data;
    sb.push_back(e);
  endtask

  // Response monitor: exactly the expected strobe on its due cycle, zero otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end else begin
        check("rsp_idle", 32'(rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           order [3];
    logic [AW-1:0] rd_addr [NR];

    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset state, with every requester asking
    req = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",       32'(gnt), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_mem_re",    32'(mem_re), 32'd0);
    check("rst_rsp",       32'(rsp_valid), 32'd0);
    mon_en = 1'b1;
    tick; rst = 1'b0; req = '0;

    // Requester 0 writes 13 to 12, later reads it back
    drive(0, 1'b1, 8'd12, 16'd13); exp_mem[12] = 16'd13;
    @(negedge clk); check("t1_wr_gnt", 32'(gnt), 32'h1);
    tick; req = '0;
    @(negedge clk);
    check("t1_mem_we",    32'(mem_we), 32'd1);
    check("t1_mem_re",    32'(mem_re), 32'd0);
    check("t1_mem_addr",  32'(mem_addr), 32'd12);
    check("t1_mem_wdata", 32'(mem_wdata), 32'd13);
    check("t1_idle_gnt",  32'(gnt), 32'd0);
    tick; drive(0, 1'b0, 8'd12, 16'd0);
    @(negedge clk); check("t1_rd_gnt", 32'(gnt), 32'h1); push(4'b0001, exp_mem[12]);
    tick; req = '0;
    @(negedge clk);
    check("t1_rd_mem_re", 32'(mem_re), 32'd1);
    check("t1_rd_mem_we", 32'(mem_we), 32'd0);
    repeat (3) tick;

    // Preload 10..13 with 100..103, back-to-back writes from requester 0
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 8'(10 + k), 16'(100 + k)); exp_mem[10 + k] = 16'(100 + k);
      @(negedge clk); check("pre_gnt", 32'(gnt), 32'h1);
      tick;
    end
    req = '0;
    repeat (2) tick;
    rst = 1'b1; tick; rst = 1'b0;

    // All four read from reset: grants 0,1,2,3 on consecutive cycles
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'(10 + k), 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("t2_gnt", 32'(gnt), 32'(1 << k));
      push(4'(1 << k), exp_mem[10 + k]);
      tick; req[k] = 1'b0;
    end
    repeat (3) tick;

    // Requester 1 writes 22 to 182, requester 2 reads it the next cycle
    drive(1, 1'b1, 8'd182, 16'd22); exp_mem[182] = 16'd22;
    @(negedge clk); check("t4_wr_gnt", 32'(gnt), 32'h2);
    tick; req = '0; drive(2, 1'b0, 8'd182, 16'd0);
    @(negedge clk); check("t4_rd_gnt", 32'(gnt), 32'h4); push(4'b0100, exp_mem[182]);
    tick; req = '0;
    repeat (3) tick;

    // Move ptr to 2 via a lone grant to requester 1, then req=1011
    drive(1, 1'b1, 8'd50, 16'd7); exp_mem[50] = 16'd7;
    @(negedge clk); check("t3_setup_gnt", 32'(gnt), 32'h2);
    tick; req = '0;
    rd_addr[0] = 8'd10; rd_addr[1] = 8'd182; rd_addr[2] = 8'd0; rd_addr[3] = 8'd13;
    drive(0, 1'b0, rd_addr[0], 16'd0);
    drive(1, 1'b0, rd_addr[1], 16'd0);
    drive(3, 1'b0, rd_addr[3], 16'd0);
    order[0] = 3; order[1] = 0; order[2] = 1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); check("t3_gnt", 32'(gnt), 32'(1 << order[j]));
      push(4'(1 << order[j]), exp_mem[rd_addr[order[j]]]);
      tick; req[order[j]] = 1'b0;
    end

    // Idle for 5 cycles, then ptr must still point at requester 2
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      check("t6_gnt",    32'(gnt), 32'd0);
      check("t6_mem_we", 32'(mem_we), 32'd0);
      check("t6_mem_re", 32'(mem_re), 32'd0);
    end
    tick;
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 8'd200, 16'd5);
    @(negedge clk); check("t6_ptr_gnt", 32'(gnt), 32'h4);
    tick; req = '0;
    @(negedge clk);
    check("t6_mem_we_after", 32'(mem_we), 32'd1);
    check("t6_mem_addr",     32'(mem_addr), 32'd200);
    repeat (2) tick;

    // Read granted, reset pulsed next cycle: response discarded
    drive(0, 1'b0, 8'd10, 16'd0);
    @(negedge clk); check("t5_rd_gnt", 32'(gnt), 32'h1);
    tick;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'(10 + k), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_gnt",       32'(gnt), 32'd0);
    check("t5_mem_we",    32'(mem_we), 32'd0);
    check("t5_mem_re",    32'(mem_re), 32'd0);
    check("t5_mem_addr",  32'(mem_addr), 32'd0);
    check("t5_mem_wdata", 32'(mem_wdata), 32'd0);
    tick;
    @(negedge clk); check("t5_rsp", 32'(rsp_valid), 32'd0);
    tick; rst = 1'b0;
    @(negedge clk); check("t5_post_gnt", 32'(gnt), 32'h1); push(4'b0001, exp_mem[10]);
    tick; req = '0;
    repeat (4) tick;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
